draw_cmd_queue: RTL

- Command sequencer in front of the draw engine. Buffers host draw-register writes (register number plus data) in a FIFO.
- Replays the buffered writes into the draw engine's register-write port one per cycle. Holds every write while the engine reports busy.
- After each EXECUTE write, waits for the engine to accept the command and finish it. The host can therefore queue many primitives without polling.
- Sits between the XR register decode and the draw engine.

---
 rtl/draw_cmd_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue
//   Command sequencer in front of the draw engine. Host draw-register writes
//   (register number + data) are buffered in a FIFO. They are replayed into the
//   engine's register-write port one per cycle while the engine is idle. After
//   an EXECUTE write, the sequencer waits for the engine to take the command and
//   finish it.
//
//   Optional build macro: DRAW_CMD_QUEUE_FLUSH_EN adds flush_i, which empties
//   the FIFO and returns the sequencer to IDLE.
//
// Ports:
//   clk             system clock
//   reset_i         asynchronous reset, active-high
//   push_i          host write strobe
//   push_num_i      host draw register number
//   push_data_i     host draw register data
//   flush_i         (DRAW_CMD_QUEUE_FLUSH_EN only) discard queue, go IDLE
//   draw_busy_i     draw engine busy
//   draw_reg_wr_o   one-cycle write strobe to the draw engine
//   draw_reg_num_o  register number to the draw engine
//   draw_reg_data_o register data to the draw engine
//   full_o/empty_o  FIFO status
//   level_o         FIFO occupancy
//   overflow_o      sticky dropped-push flag
//   clr_overflow_i  clears overflow_o
//   busy_o          queue non-empty, sequencer active or engine busy
module draw_cmd_queue #(
  parameter int         DEPTH        = 16,
  parameter int         GUARD_CYCLES = 4,
  parameter logic [5:0] EXEC_REG     = 6'h0F
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [5:0]               push_num_i,
  input  logic [15:0]              push_data_i,
`ifdef DRAW_CMD_QUEUE_FLUSH_EN
  input  logic                     flush_i,
`endif
  input  logic                     draw_busy_i,
  output logic                     draw_reg_wr_o,
  output logic [5:0]               draw_reg_num_o,
  output logic [15:0]              draw_reg_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     clr_overflow_i,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GUARD     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [21:0]   mem_q [DEPTH];
  logic [PW-1:0] level;
  logic          full, empty, flush;
  logic          push_ok, push_rej, pop;
  logic [21:0]   head;
  logic          wr_q;
  logic [5:0]    num_q;
  logic [15:0]   data_q;
  logic          ovf_q;

`ifdef DRAW_CMD_QUEUE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Pointers carry one extra bit, so full and empty are told apart by the difference.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Acceptance depends only on full. A same-edge pop never makes room.
  assign push_ok  = push_i && !full && !flush;
  assign push_rej = push_i &&  full && !flush;
  // Pops need an empty-free FIFO, so on an empty FIFO a simultaneous push is simply stored.
  assign pop      = (state_q == IDLE) && !empty && !draw_busy_i && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pop && (head[21:16] == EXEC_REG)) begin
          state_d = GUARD;
          cnt_d   = 4'(GUARD_CYCLES);
        end
      end
      GUARD: begin
        if (draw_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // Engine never went busy: the opcode was a no-op.
          if (cnt_q <= 4'd1) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!draw_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_q     <= 1'b0;
      num_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      wr_q <= pop;
      if (pop) begin
        num_q  <= head[21:16];
        data_q <= head[15:0];
      end
      // A dropped push wins over a same-edge clear.
      if (push_rej)            ovf_q <= 1'b1;
      else if (clr_overflow_i) ovf_q <= 1'b0;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {push_num_i, push_data_i};
  end

  assign draw_reg_wr_o   = wr_q;
  assign draw_reg_num_o  = num_q;
  assign draw_reg_data_o = data_q;
  assign full_o          = full;
  assign empty_o         = empty;
  assign level_o         = level;
  assign overflow_o      = ovf_q;
  assign busy_o          = !empty || (state_q != IDLE) || draw_busy_i;

endmodule
